// File: rtl/sg_desc_builder.sv
// Scatter-gather descriptor ring builder: writes one 8-beat AXI burst per
// descriptor, linking each descriptor to the next and wrapping to the first.
module sg_desc_builder #(
   parameter logic [3:0] AXI_ID = 4'h0
) (
   input  logic        s_aclk,
   input  logic        s_areset,
   input  logic        start,
   input  logic [31:0] desc_base,
   input  logic [31:0] buf_base,
   input  logic [31:0] buf_stride,
   input  logic [25:0] buf_len,
   input  logic [7:0]  desc_count,
   output logic        busy,
   output logic        done,
   output logic        error,
   output logic [31:0] tail_desc,
   output logic [3:0]  m_axi_awid,
   output logic [31:0] m_axi_awaddr,
   output logic [7:0]  m_axi_awlen,
   output logic [2:0]  m_axi_awsize,
   output logic [1:0]  m_axi_awburst,
   output logic        m_axi_awvalid,
   input  logic        m_axi_awready,
   output logic [31:0] m_axi_wdata,
   output logic [3:0]  m_axi_wstrb,
   output logic        m_axi_wlast,
   output logic        m_axi_wvalid,
   input  logic        m_axi_wready,
   input  logic [3:0]  m_axi_bid,
   input  logic [1:0]  m_axi_bresp,
   input  logic        m_axi_bvalid,
   output logic        m_axi_bready
);

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_AW   = 3'd1;
   localparam logic [2:0] S_W    = 3'd2;
   localparam logic [2:0] S_B    = 3'd3;
   localparam logic [2:0] S_FIN  = 3'd4;

   logic [2:0]  state;
   logic [7:0]  idx;
   logic [7:0]  n;
   logic [2:0]  beat;
   logic [31:0] ring;
   logic [31:0] cur_desc;
   logic [31:0] cur_buf;
   logic [31:0] stride;
   logic [25:0] blen;
   logic        last_desc;
   logic [7:0]  n_m1;
   logic [31:0] next_desc;
   logic        unused_ok;

   assign last_desc = (idx == n_m1);
   assign n_m1      = n - 8'd1;
   // The last descriptor links back to the head of the ring.
   assign next_desc = last_desc ? ring : cur_desc + 32'd64;
   assign unused_ok = ^{m_axi_bid, desc_base[5:0]};

   always_ff @(posedge s_aclk) begin
      if (s_areset) begin
         state     <= S_IDLE;
         idx       <= 8'd0;
         n         <= 8'd0;
         beat      <= 3'd0;
         ring      <= 32'd0;
         cur_desc  <= 32'd0;
         cur_buf   <= 32'd0;
         stride    <= 32'd0;
         blen      <= 26'd0;
         busy      <= 1'b0;
         done      <= 1'b0;
         error     <= 1'b0;
         tail_desc <= 32'd0;
      end else begin
         done <= 1'b0;
         unique case (state)
            S_IDLE: begin
               if (start) begin
                  ring     <= {desc_base[31:6], 6'd0};
                  cur_desc <= {desc_base[31:6], 6'd0};
                  cur_buf  <= buf_base;
                  stride   <= buf_stride;
                  blen     <= buf_len;
                  n        <= desc_count;
                  idx      <= 8'd0;
                  beat     <= 3'd0;
                  error    <= 1'b0;
                  busy     <= 1'b1;
                  state    <= (desc_count == 8'd0) ? S_FIN : S_AW;
               end
            end
            S_AW: begin
               if (m_axi_awready) state <= S_W;
            end
            S_W: begin
               if (m_axi_wready) begin
                  beat <= beat + 3'd1;
                  if (beat == 3'd7) state <= S_B;
               end
            end
            S_B: begin
               if (m_axi_bvalid) begin
                  if (m_axi_bresp != 2'b00) begin
                     error <= 1'b1;
                     state <= S_FIN;
                  end else if (last_desc) begin
                     state <= S_FIN;
                  end else begin
                     idx      <= idx + 8'd1;
                     cur_desc <= cur_desc + 32'd64;
                     cur_buf  <= cur_buf + stride;
                     state    <= S_AW;
                  end
               end
            end
            S_FIN: begin
               done      <= 1'b1;
               busy      <= 1'b0;
               tail_desc <= (n == 8'd0) ? ring
                          : ring + {18'd0, n_m1, 6'd0};
               state     <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign m_axi_awid    = AXI_ID;
   assign m_axi_awaddr  = cur_desc;
   assign m_axi_awlen   = 8'd7;
   assign m_axi_awsize  = 3'd2;
   assign m_axi_awburst = 2'b01;
   assign m_axi_awvalid = (state == S_AW);
   assign m_axi_wvalid  = (state == S_W);
   assign m_axi_wstrb   = 4'hF;
   assign m_axi_wlast   = (state == S_W) && (beat == 3'd7);
   assign m_axi_bready  = (state == S_B);

   always_comb begin
      m_axi_wdata = 32'd0;
      unique case (beat)
         3'd0:    m_axi_wdata = next_desc;
         3'd2:    m_axi_wdata = cur_buf;
         3'd6:    m_axi_wdata = {6'b000011, blen};
         default: m_axi_wdata = 32'd0;
      endcase
   end

endmodule

// File: tb/tb_sg_desc_builder.sv
// Bench for sg_desc_builder: stalling AXI write slave with memory, plus a
// formula-based model of the expected descriptor ring contents.
module tb_sg_desc_builder;

   logic        s_aclk = 1'b0;
   logic        s_areset;
   logic        start;
   logic [31:0] desc_base;
   logic [31:0] buf_base;
   logic [31:0] buf_stride;
   logic [25:0] buf_len;
   logic [7:0]  desc_count;
   logic        busy;
   logic        done;
   logic        error;
   logic [31:0] tail_desc;
   logic [3:0]  m_axi_awid;
   logic [31:0] m_axi_awaddr;
   logic [7:0]  m_axi_awlen;
   logic [2:0]  m_axi_awsize;
   logic [1:0]  m_axi_awburst;
   logic        m_axi_awvalid;
   logic        m_axi_awready;
   logic [31:0] m_axi_wdata;
   logic [3:0]  m_axi_wstrb;
   logic        m_axi_wlast;
   logic        m_axi_wvalid;
   logic        m_axi_wready;
   logic [3:0]  m_axi_bid;
   logic [1:0]  m_axi_bresp;
   logic        m_axi_bvalid;
   logic        m_axi_bready;

   sg_desc_builder #(.AXI_ID(4'h5)) dut (
      .s_aclk(s_aclk), .s_areset(s_areset), .start(start),
      .desc_base(desc_base), .buf_base(buf_base),
      .buf_stride(buf_stride), .buf_len(buf_len),
      .desc_count(desc_count), .busy(busy), .done(done),
      .error(error), .tail_desc(tail_desc),
      .m_axi_awid(m_axi_awid), .m_axi_awaddr(m_axi_awaddr),
      .m_axi_awlen(m_axi_awlen), .m_axi_awsize(m_axi_awsize),
      .m_axi_awburst(m_axi_awburst), .m_axi_awvalid(m_axi_awvalid),
      .m_axi_awready(m_axi_awready), .m_axi_wdata(m_axi_wdata),
      .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
      .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
      .m_axi_bid(m_axi_bid), .m_axi_bresp(m_axi_bresp),
      .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready)
   );

   always #5 s_aclk = ~s_aclk;

   int checks = 0;
   int failures = 0;

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Slave state
   logic [31:0] mem [logic [31:0]];
   bit          stall = 0;
   int          err_burst = -1;
   int          aw_cnt = 0;
   int          b_cnt = 0;
   bit          aw_seen = 0;
   int          w_beat = 0;
   int          aw_wait = 0;
   int          w_wait = 0;
   bit          b_pend = 0;
   bit          aw_hold = 0;
   bit          w_hold = 0;
   logic [31:0] hold_awaddr;
   logic [31:0] hold_wdata;
   logic        hold_wlast;
   logic [31:0] cur_addr = 0;

   // Slave reacts on the falling edge; everything it decides here is what
   // the DUT samples on the following rising edge.
   always @(negedge s_aclk) begin
      if (s_areset) begin
         m_axi_awready = 1'b0;
         m_axi_wready  = 1'b0;
         m_axi_bvalid  = 1'b0;
         m_axi_bresp   = 2'b00;
         b_pend  = 0;
         w_beat  = 0;
         aw_wait = 0;
         w_wait  = 0;
         aw_hold = 0;
         w_hold  = 0;
      end else begin
         if (aw_hold) begin
            check("aw_hold_valid", 32'(m_axi_awvalid), 32'd1);
            check("aw_hold_addr", m_axi_awaddr, hold_awaddr);
         end
         if (w_hold) begin
            check("w_hold_valid", 32'(m_axi_wvalid), 32'd1);
            check("w_hold_data", m_axi_wdata, hold_wdata);
            check("w_hold_last", 32'(m_axi_wlast), 32'(hold_wlast));
         end
         if (m_axi_awvalid) aw_seen = 1;
         m_axi_awready = (aw_wait == 0);
         m_axi_wready  = (w_wait == 0);
         m_axi_bvalid  = b_pend;
         m_axi_bresp   = (b_cnt == err_burst) ? 2'b10 : 2'b00;
         aw_hold     = m_axi_awvalid && !m_axi_awready;
         hold_awaddr = m_axi_awaddr;
         w_hold      = m_axi_wvalid && !m_axi_wready;
         hold_wdata  = m_axi_wdata;
         hold_wlast  = m_axi_wlast;
         if (m_axi_awvalid && m_axi_awready) begin
            check("aw_fields", {m_axi_awid, m_axi_awlen, 1'b0,
                  m_axi_awsize, m_axi_awburst, 1'b0, m_axi_wvalid},
                  {4'h5, 8'd7, 1'b0, 3'd2, 2'b01, 1'b0, 1'b0});
            cur_addr = m_axi_awaddr;
            w_beat   = 0;
            aw_cnt++;
            aw_wait  = stall ? $urandom_range(0, 5) : 0;
         end else if (m_axi_awvalid && aw_wait > 0) begin
            aw_wait--;
         end
         if (m_axi_wvalid && m_axi_wready) begin
            mem[cur_addr + 32'(4 * w_beat)] = m_axi_wdata;
            check("w_strb_last", {m_axi_wstrb, 3'd0, m_axi_wlast},
                  {4'hF, 3'd0, 1'(w_beat == 7)});
            w_beat++;
            if (w_beat == 8) b_pend = 1;
            w_wait = stall ? $urandom_range(0, 5) : 0;
         end else if (m_axi_wvalid && w_wait > 0) begin
            w_wait--;
         end
         if (m_axi_bvalid && m_axi_bready) begin
            b_pend = 0;
            b_cnt++;
         end
      end
   end

   function automatic logic [31:0] rd(input logic [31:0] a);
      return mem.exists(a) ? mem[a] : 32'hDEAD_BEEF;
   endfunction

   // Expected ring contents from the descriptor layout formulas.
   task automatic cmp_mem(input logic [31:0] base, input logic [31:0] bb,
                          input logic [31:0] str, input logic [25:0] len,
                          input int n, input int nb);
      logic [31:0] d0;
      logic [31:0] exp;
      d0 = base & ~32'h3F;
      check("mem_words", 32'(mem.num()), 32'(nb * 8));
      for (int i = 0; i < nb; i++) begin
         for (int b = 0; b < 8; b++) begin
            case (b)
               0:       exp = d0 + 32'(64 * ((i + 1) % n));
               2:       exp = bb + 32'(i) * str;
               6:       exp = 32'h0C00_0000 | {6'd0, len};
               default: exp = 32'd0;
            endcase
            check($sformatf("mem_d%0d_b%0d", i, b),
                  rd(d0 + 32'(64 * i + 4 * b)), exp);
         end
      end
   endtask

   task automatic run(input logic [31:0] base, input logic [31:0] bb,
                      input logic [31:0] str, input logic [25:0] len,
                      input int n, input bit stl, input int eb,
                      input bit rep, output int lat);
      int nb;
      bit err;
      logic [31:0] d0;
      mem.delete();
      aw_cnt = 0; b_cnt = 0; aw_seen = 0;
      stall = stl; err_burst = eb;
      desc_base = base; buf_base = bb; buf_stride = str;
      buf_len = len; desc_count = 8'(n);
      start = 1'b1;
      @(posedge s_aclk); #1;
      start = 1'b0;
      check("busy_after_start", 32'(busy), 32'd1);
      check("error_cleared", 32'(error), 32'd0);
      lat = 1;
      while (!done && lat < 4000) begin
         @(posedge s_aclk); #1;
         lat++;
         if (rep && lat == 3) begin
            desc_base = 32'h9000; desc_count = 8'd5;
            buf_base = 32'h1; start = 1'b1;
         end else begin
            start = 1'b0;
         end
      end
      start = 1'b0;
      err = (eb >= 0 && eb < n);
      nb  = err ? eb + 1 : n;
      d0  = base & ~32'h3F;
      check("done_seen", 32'(done), 32'd1);
      check("tail_desc", tail_desc,
            (n == 0) ? d0 : d0 + 32'(64 * (n - 1)));
      check("error_flag", 32'(error), 32'(err));
      check("aw_bursts", 32'(aw_cnt), 32'(nb));
      @(posedge s_aclk); #1;
      check("done_single", 32'(done), 32'd0);
      check("busy_idle", 32'(busy), 32'd0);
      check("error_sticky", 32'(error), 32'(err));
      cmp_mem(base, bb, str, len, n, nb);
   endtask

   initial begin
      int lat;
      int k;
      s_areset = 1'b1; start = 1'b0;
      desc_base = 0; buf_base = 0; buf_stride = 0;
      buf_len = 0; desc_count = 0;
      repeat (3) @(posedge s_aclk);
      #1;
      check("rst_outputs", {28'd0, busy, done, error, m_axi_awvalid},
            32'd0);
      check("rst_ch", {29'd0, m_axi_wvalid, m_axi_wlast, m_axi_bready},
            32'd0);
      check("rst_tail", tail_desc, 32'd0);
      s_areset = 1'b0;
      @(posedge s_aclk); #1;

      run(32'h1000, 32'h8000_0000, 32'h100, 26'h40, 3, 0, -1, 0, lat);
      check("ring_wrap", rd(32'h1080), 32'h1000);
      check("ring_flags", rd(32'h1018), 32'h0C00_0040);

      run(32'h2345, 32'h5, 32'h7, 26'h9, 0, 0, -1, 0, lat);
      check("n0_latency", 32'(lat), 32'd2);
      check("n0_no_aw", 32'(aw_seen), 32'd0);

      run(32'h1000, 32'h8000_0000, 32'h100, 26'h40, 4, 1, -1, 0, lat);

      run(32'h4000, 32'h1234_0000, 32'h80, 26'h3FF_FFFF, 4, 1, 1, 0, lat);
      run(32'h4000, 32'hA, 32'hB, 26'hC, 1, 0, -1, 0, lat);

      run(32'h2000, 32'h300, 32'h40, 26'h20, 2, 0, -1, 1, lat);

      desc_base = 32'h6000; buf_base = 32'h0; buf_stride = 32'h4;
      buf_len = 26'h8; desc_count = 8'd3;
      mem.delete(); stall = 0; err_burst = -1; aw_cnt = 0; b_cnt = 0;
      start = 1'b1;
      @(posedge s_aclk); #1;
      start = 1'b0;
      k = 0;
      while (!(w_beat == 3 && m_axi_wvalid) && k < 200) begin
         @(posedge s_aclk); #1;
         k++;
      end
      check("reach_w_beat3", 32'(k < 200), 32'd1);
      s_areset = 1'b1;
      @(posedge s_aclk); #1;
      s_areset = 1'b0;
      check("abort_valids", {29'd0, m_axi_awvalid, m_axi_wvalid,
            m_axi_bready}, 32'd0);
      check("abort_status", {29'd0, busy, done, error}, 32'd0);
      check("abort_tail", tail_desc, 32'd0);
      @(posedge s_aclk); #1;
      run(32'h6000, 32'h0, 32'h4, 26'h8, 3, 0, -1, 0, lat);

      for (int t = 0; t < 6; t++) begin
         run($urandom, $urandom, $urandom, 26'($urandom),
             int'($urandom_range(1, 6)), 1'($urandom_range(0, 1)),
             -1, 0, lat);
      end
      run($urandom, $urandom, $urandom, 26'($urandom), 5, 1, 3, 0, lat);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
